// File: rtl/sharpen_pkg.sv
// Shared types and constants for the 3x3 sharpening frame controller.
package sharpen_pkg;
  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN} state_e;
  localparam int NUM_LB = 3;
endpackage

// File: rtl/raster_counter.sv
// Raster col/row position counter with enable, look-ahead wrap flags and sync clear.
module raster_counter #(
  parameter int COLS = 3840,
  parameter int ROWS = 2160,
  parameter int CW   = 14,
  parameter int RW   = 12
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          col_wrap_o,
  output logic          frame_wrap_o
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Wrap flags mean "the next enabled advance wraps", not gated by en_i.
  assign col_wrap_o   = (col_q == CW'(COLS-1));
  assign frame_wrap_o = col_wrap_o && (row_q == RW'(ROWS-1));
  assign col_o        = col_q;
  assign row_o        = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (en_i) begin
      if (col_wrap_o) begin
        col_d = '0;
        row_d = frame_wrap_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/sharpen_frame_ctrl.sv
// Frame sequencer: input raster tracking, line-buffer write control, window
// centre generation, end-of-frame flush and drain.
module sharpen_frame_ctrl
  import sharpen_pkg::*;
#(
  parameter int COLS      = 3840,
  parameter int ROWS      = 2160,
  parameter int LINE_BITS = 14,
  parameter int ROW_BITS  = 12,
  parameter int PIPE_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 lb_wr_en,
  output logic [1:0]           lb_sel,
  output logic [LINE_BITS-1:0] lb_addr,
  output logic                 win_valid,
  output logic [ROW_BITS-1:0]  win_row,
  output logic [LINE_BITS-1:0] win_col,
  output logic                 border,
  output logic                 flush_active,
  output logic                 out_valid,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err_overrun
);
  localparam int DW = $clog2(PIPE_LAT+1) + 1;

  state_e               state_q, state_d;
  logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [1:0]           sel_q, sel_d;
  logic                 accept, win_fire, frame_end, c_border;
  logic [LINE_BITS-1:0] in_col, c_col;
  logic [ROW_BITS-1:0]  in_row, c_row;
  logic                 in_cwrap, in_fwrap, c_cwrap, c_fwrap;

  logic                 lb_wr_en_q, win_valid_q, border_q, frame_done_q, err_q;
  logic [1:0]           lb_sel_q;
  logic [LINE_BITS-1:0] lb_addr_q, win_col_q;
  logic [ROW_BITS-1:0]  win_row_q;
  logic [PIPE_LAT-1:0]  vld_q;

  assign in_ready  = (state_q == IDLE) || (state_q == FILL) || (state_q == RUN);
  assign accept    = in_valid && in_ready;
  // During FLUSH the window centre keeps advancing with zero-injected input.
  assign win_fire  = (accept && state_q == RUN) || (state_q == FLUSH);
  assign frame_end = (state_q == DRAIN) && (drain_cnt_q == DW'(PIPE_LAT));
  assign c_border  = (c_row == '0) || (c_row == ROW_BITS'(ROWS-1)) ||
                     (c_col == '0) || c_cwrap;

  raster_counter #(.COLS(COLS), .ROWS(ROWS), .CW(LINE_BITS), .RW(ROW_BITS)) u_in_pos (
    .clk(clk), .clr_i(reset), .en_i(accept),
    .col_o(in_col), .row_o(in_row), .col_wrap_o(in_cwrap), .frame_wrap_o(in_fwrap)
  );

  raster_counter #(.COLS(COLS), .ROWS(ROWS), .CW(LINE_BITS), .RW(ROW_BITS)) u_ctr_pos (
    .clk(clk), .clr_i(reset), .en_i(win_fire),
    .col_o(c_col), .row_o(c_row), .col_wrap_o(c_cwrap), .frame_wrap_o(c_fwrap)
  );

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    sel_d       = sel_q;
    if (accept && in_cwrap)
      sel_d = (sel_q == 2'(NUM_LB-1)) ? 2'd0 : sel_q + 2'd1;
    unique case (state_q)
      IDLE:  if (accept) state_d = FILL;
      // Pixel COLS is the first at row 1, col 0.
      FILL:  if (accept && in_row == ROW_BITS'(1) && in_col == '0) state_d = RUN;
      RUN:   if (accept && in_fwrap) state_d = FLUSH;
      FLUSH: if (c_fwrap) begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
             end
      DRAIN: begin
               drain_cnt_d = drain_cnt_q + 1'b1;
               if (frame_end) begin
                 state_d = IDLE;
                 sel_d   = '0;
               end
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      drain_cnt_q  <= '0;
      sel_q        <= '0;
      lb_wr_en_q   <= 1'b0;
      lb_sel_q     <= '0;
      lb_addr_q    <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      border_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      vld_q        <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      sel_q        <= sel_d;
      lb_wr_en_q   <= accept;
      if (accept) begin
        lb_sel_q  <= sel_q;
        lb_addr_q <= in_col;
      end
      win_valid_q  <= win_fire;
      if (win_fire) begin
        win_row_q <= c_row;
        win_col_q <= c_col;
      end
      border_q     <= win_fire && c_border;
      frame_done_q <= frame_end;
      err_q        <= in_valid && !in_ready;
      vld_q[0]     <= win_valid_q;
      for (int i = 1; i < PIPE_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign lb_wr_en     = lb_wr_en_q;
  assign lb_sel       = lb_sel_q;
  assign lb_addr      = lb_addr_q;
  assign win_valid    = win_valid_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;
  assign border       = border_q;
  assign flush_active = (state_q == FLUSH);
  assign out_valid    = vld_q[PIPE_LAT-1];
  assign frame_done   = frame_done_q;
  assign busy         = (state_q != IDLE);
  assign err_overrun  = err_q;
endmodule

// File: tb/tb_sharpen_frame_ctrl.sv
// Directed bench for sharpen_frame_ctrl on a 4x3 frame with PIPE_LAT=2.
module tb_sharpen_frame_ctrl;
  localparam int COLS = 4, ROWS = 3, LB = 3, RB = 2, PL = 2;

  logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic          in_ready, lb_wr_en, win_valid, border, flush_active;
  logic          out_valid, frame_done, busy, err_overrun;
  logic [1:0]    lb_sel;
  logic [LB-1:0] lb_addr, win_col;
  logic [RB-1:0] win_row;

  sharpen_frame_ctrl #(.COLS(COLS), .ROWS(ROWS), .LINE_BITS(LB), .ROW_BITS(RB), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .lb_wr_en(lb_wr_en), .lb_sel(lb_sel), .lb_addr(lb_addr),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .border(border),
    .flush_active(flush_active), .out_valid(out_valid), .frame_done(frame_done),
    .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int acc_cyc[$], wr_cyc[$], sel_seq[$], addr_seq[$];
  int win_cyc[$], win_r[$], win_c[$], win_b[$];
  int n_fd, fd_cyc, n_flush, n_flush_rdy, n_ovr, n_ov, last_ov, n_bord_idle;
  bit exp_b [12] = '{1,1,1,1, 1,0,0,1, 1,1,1,1};

  // Passive recorder, sampled mid-cycle; accept is logged in the cycle before its edge.
  always @(negedge clk) begin
    if (in_valid && in_ready && !reset) acc_cyc.push_back(cyc);
    if (lb_wr_en) begin
      wr_cyc.push_back(cyc); sel_seq.push_back(int'(lb_sel)); addr_seq.push_back(int'(lb_addr));
    end
    if (win_valid) begin
      win_cyc.push_back(cyc); win_r.push_back(int'(win_row));
      win_c.push_back(int'(win_col)); win_b.push_back(int'(border));
    end else if (border) n_bord_idle++;
    if (flush_active) begin n_flush++; if (in_ready) n_flush_rdy++; end
    if (frame_done) begin n_fd++; fd_cyc = cyc; end
    if (err_overrun) n_ovr++;
    if (out_valid) begin n_ov++; last_ov = cyc; end
  end

  task automatic clear_mon();
    acc_cyc.delete(); wr_cyc.delete(); sel_seq.delete(); addr_seq.delete();
    win_cyc.delete(); win_r.delete(); win_c.delete(); win_b.delete();
    n_fd = 0; fd_cyc = 0; n_flush = 0; n_flush_rdy = 0; n_ovr = 0;
    n_ov = 0; last_ov = 0; n_bord_idle = 0;
  endtask

  task automatic drive_frame(input int n, input int gap, input bit ovr);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; @(posedge clk); #1;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    in_valid = 1'b0;
    if (ovr) begin
      @(posedge clk); #1; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (n_fd == 0 && t < 200) begin @(posedge clk); #1; t++; end
    if (n_fd == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: frame_done not seen within %0d cycles", tag, t);
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({lb_wr_en, lb_sel, lb_addr, win_valid, win_row, win_col, border, flush_active,
         out_valid, frame_done, err_overrun} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: some output nonzero (wr=%b sel=%0d addr=%0d wv=%b fd=%b)",
                        lb_wr_en, lb_sel, lb_addr, win_valid, frame_done);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_mon();
    drive_frame(12, 0, 1'b0);
    wait_done("basic");
    n_cmp++;
    if (win_cyc.size() !== 12) begin n_bad++; $display("FAIL basic_win_count: got %0d want 12", win_cyc.size()); end
    n_cmp++;
    if (acc_cyc.size() != 12 || win_cyc.size() == 0 || win_cyc[0] !== acc_cyc[5] + 1) begin
      n_bad++; $display("FAIL basic_first_win: win_valid not one cycle after 6th accept");
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= win_r.size() || win_r[i] !== i / COLS || win_c[i] !== i % COLS) begin
        n_bad++; $display("FAIL basic_centre[%0d]: wrong centre, want (%0d,%0d)", i, i / COLS, i % COLS);
      end
      n_cmp++;
      if (i >= sel_seq.size() || sel_seq[i] !== i / COLS || addr_seq[i] !== i % COLS) begin
        n_bad++; $display("FAIL basic_lb[%0d]: wrong sel/addr, want sel=%0d addr=%0d", i, i / COLS, i % COLS);
      end
    end
    n_cmp++;
    if (n_flush !== 5 || n_flush_rdy !== 0) begin
      n_bad++; $display("FAIL basic_flush: %0d flush cycles (%0d with in_ready) want 5 (0)", n_flush, n_flush_rdy);
    end
    n_cmp++;
    if (win_cyc.size() != 12 || fd_cyc !== win_cyc[11] + 3) begin
      n_bad++; $display("FAIL basic_done_lat: frame_done at %0d, want last win_valid + 3", fd_cyc);
    end
    n_cmp++;
    if (acc_cyc.size() == 0 || fd_cyc - acc_cyc[0] !== 20) begin
      n_bad++; $display("FAIL basic_frame_len: got %0d want 20", fd_cyc - acc_cyc[0]);
    end
    n_cmp++;
    if (n_fd !== 1 || n_ov !== 12 || fd_cyc !== last_ov + 1) begin
      n_bad++; $display("FAIL basic_out_valid: fd=%0d ov=%0d fd_cyc=%0d last_ov=%0d want 1,12,last+1",
                        n_fd, n_ov, fd_cyc, last_ov);
    end
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL basic_idle: busy=%b in_ready=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_border();
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= win_b.size() || win_b[i] !== int'(exp_b[i])) begin
        n_bad++; $display("FAIL border[%0d]: centre (%0d,%0d) want %0d", i, i / COLS, i % COLS, exp_b[i]);
      end
    end
    n_cmp++;
    if (n_bord_idle !== 0) begin n_bad++; $display("FAIL border_idle: got %0d want 0", n_bord_idle); end
  endtask

  task automatic test_gaps();
    clear_mon();
    drive_frame(12, 1, 1'b0);
    wait_done("gaps");
    n_cmp++;
    if (win_cyc.size() !== 12 || acc_cyc.size() !== 12) begin
      n_bad++; $display("FAIL gaps_count: win=%0d acc=%0d want 12/12", win_cyc.size(), acc_cyc.size());
    end
    for (int i = 0; i < 12 && i < acc_cyc.size(); i++) begin
      n_cmp++;
      if (i >= wr_cyc.size() || wr_cyc[i] !== acc_cyc[i] + 1) begin
        n_bad++; $display("FAIL gaps_wr[%0d]: lb_wr_en not on cycle %0d", i, acc_cyc[i] + 1);
      end
    end
    for (int i = 0; i < 7 && acc_cyc.size() == 12; i++) begin
      n_cmp++;
      if (i >= win_cyc.size() || win_cyc[i] !== acc_cyc[i+5] + 1) begin
        n_bad++; $display("FAIL gaps_win[%0d]: win_valid not on cycle %0d", i, acc_cyc[i+5] + 1);
      end
    end
    n_cmp++;
    if (acc_cyc.size() == 0 || fd_cyc - acc_cyc[0] !== 31) begin
      n_bad++; $display("FAIL gaps_frame_len: got %0d want 31", fd_cyc - acc_cyc[0]);
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    drive_frame(12, 0, 1'b1);
    wait_done("ovr");
    n_cmp++;
    if (n_ovr !== 1) begin n_bad++; $display("FAIL ovr_pulse: %0d cycles high want 1", n_ovr); end
    n_cmp++;
    if (win_cyc.size() !== 12 || acc_cyc.size() !== 12) begin
      n_bad++; $display("FAIL ovr_count: win=%0d acc=%0d want 12/12", win_cyc.size(), acc_cyc.size());
    end
    n_cmp++;
    if (acc_cyc.size() == 0 || fd_cyc - acc_cyc[0] !== 20) begin
      n_bad++; $display("FAIL ovr_frame_len: got %0d want 20", fd_cyc - acc_cyc[0]);
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    drive_frame(7, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({lb_wr_en, lb_sel, lb_addr, win_valid, win_row, win_col, border, flush_active,
         busy, err_overrun} !== '0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_clear: wr=%b sel=%0d addr=%0d wv=%b busy=%b rdy=%b want all 0, rdy 1",
                        lb_wr_en, lb_sel, lb_addr, win_valid, busy, in_ready);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++;
    if (n_fd !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", n_fd); end
    clear_mon();
    drive_frame(12, 0, 1'b0);
    wait_done("midrst");
    n_cmp++;
    if (win_cyc.size() !== 12 || acc_cyc.size() != 12 || win_cyc[0] !== acc_cyc[5] + 1) begin
      n_bad++; $display("FAIL midrst_win: count=%0d or stale first window", win_cyc.size());
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= win_r.size() || i >= sel_seq.size() || win_r[i] !== i / COLS || win_c[i] !== i % COLS ||
          sel_seq[i] !== i / COLS || addr_seq[i] !== i % COLS) begin
        n_bad++; $display("FAIL midrst_seq[%0d]: want centre (%0d,%0d) sel=%0d addr=%0d",
                          i, i / COLS, i % COLS, i / COLS, i % COLS);
      end
    end
    n_cmp++;
    if (n_fd !== 1) begin n_bad++; $display("FAIL midrst_done: got %0d pulses want 1", n_fd); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_border();
    test_gaps();
    test_overrun();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sharpen_frame_ctrl.md
# sharpen_frame_ctrl

Frame sequencer for the 3×3 RGB sharpening datapath. It accepts the raster pixel stream and tracks row and column position. It drives write enables and addresses for the three rotating line buffers, and marks when a full 3×3 window is centred on a valid pixel, flagging border pixels for pass-through. At end of frame it flushes the pipeline and reports completion with a one-cycle `frame_done` pulse.

## Interface
- `COLS`, 3840: pixels per line.
- `ROWS`, 2160: lines per frame.
- `LINE_BITS`, 14: column/address counter width; must satisfy 2^LINE_BITS ≥ COLS.
- `ROW_BITS`, 12: row counter width; must satisfy 2^ROW_BITS ≥ ROWS.
- `PIPE_LAT`, 3: filter arithmetic latency in cycles, ≥1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  pixel present on the datapath input this cycle.
- `in_ready`  out  1  controller accepts pixels.
- `lb_wr_en`  out  1  write the current pixel into the line buffer selected by `lb_sel`.
- `lb_sel`  out  2  line buffer being written (0,1,2, rotating).
- `lb_addr`  out  LINE_BITS  line-buffer column address.
- `win_valid`  out  1  3×3 window centred on (`win_row`,`win_col`) is present.
- `win_row`  out  ROW_BITS  centre row.
- `win_col`  out  LINE_BITS  centre column.
- `border`  out  1  centre lies on a frame edge; output equals the unfiltered pixel.
- `flush_active`  out  1  datapath must inject zeros instead of input pixels.
- `out_valid`  out  1  `win_valid` delayed PIPE_LAT cycles; drives `data_out_done`.
- `frame_done`  out  1  single-cycle pulse after the last `out_valid`.
- `busy`  out  1  state ≠ IDLE.
- `err_overrun`  out  1  single-cycle pulse: `in_valid` seen while `in_ready`=0.

## Operation
- **Accept rule:** a pixel is accepted when `in_valid` && `in_ready`.
- **Input counters:** `in_col` and `in_row` advance on every accepted pixel. `in_col` wraps at COLS-1. `in_row` increments on that wrap.
- **Line-buffer select:** `lb_sel` increments modulo 3 on each column wrap.
- **Line-buffer address:** `lb_addr` equals `in_col` of the accepted pixel.
- **Accepted count:** linear count k. The window for centre index k−(COLS+1) becomes available when pixel k is accepted.
- **States:**
  - IDLE → FILL on first accepted pixel.
  - FILL → RUN when k = COLS (the (COLS+1)th pixel is accepted).
  - RUN → FLUSH after pixel k = ROWS·COLS−1 is accepted.
  - FLUSH generates COLS+1 internal window-advance cycles with `flush_active`=1 and `in_ready`=0.
  - FLUSH → DRAIN; DRAIN waits PIPE_LAT cycles.
  - DRAIN → IDLE with `frame_done`=1 on the final cycle.
- **`win_valid`:** asserted once per accepted pixel in RUN and once per FLUSH cycle. The centre counters start at (0,0) and advance raster-wise. Exactly ROWS·COLS assertions occur per frame.
- **`border`:** 1 when `win_row`∈{0,ROWS−1} or `win_col`∈{0,COLS−1}; 0 whenever `win_valid`=0.
- **`in_ready`:** 1 in IDLE, FILL and RUN; 0 in FLUSH and DRAIN.
- **Overrun:** `in_valid` while `in_ready`=0 pulses `err_overrun`. The pixel is dropped and no counter changes.
- **Gaps:** `in_valid`=0 in FILL or RUN stalls all counters and deasserts `win_valid` and `lb_wr_en`.
- **Reset:** all counters, state and outputs clear, `in_ready`=1 and `frame_done` is not pulsed. This applies at any time, including mid-frame. The next frame starts at (0,0) with `lb_sel`=0.

## Timing
- `lb_wr_en`, `lb_sel`, `lb_addr`, `win_valid`, `win_row`, `win_col` and `border` are registered: they appear one cycle after the accepting edge.
- `out_valid` is `win_valid` delayed by exactly PIPE_LAT cycles through a shift register.
- `frame_done` is asserted on the cycle after the last `out_valid`.
- Continuous input: frame cycle count from first accept to `frame_done` is ROWS·COLS + COLS + 1 + PIPE_LAT + 1.
- Reset values: all outputs 0 except `in_ready`=1.

## Structure
- Shared package `sharpen_pkg`: state enum (IDLE, FILL, RUN, FLUSH, DRAIN) and constant `NUM_LB`=3.
- One sub-module, `raster_counter`: a col/row counter with enable, wrap outputs and synchronous clear. It is instantiated twice, once for the input position and once for the window centre.

## Test plan
Bench parameters: COLS=4, ROWS=3, PIPE_LAT=2.
1. Hold reset 3 cycles → all outputs 0, `in_ready`=1, `busy`=0.
2. 12 contiguous pixels → first `win_valid` one cycle after the 6th accept, centre (0,0), `border`=1. `lb_sel` sequence is 0×4, 1×4, 2×4. FLUSH lasts 5 cycles with `in_ready`=0. There are 12 `win_valid` in total. `frame_done` is asserted 3 cycles after the last `win_valid`.
3. Border check on the same frame → `border`=0 only for centres (1,1) and (1,2); all other 10 centres have `border`=1.
4. `in_valid` toggling 1,0,1,0 → `win_valid` and `lb_wr_en` follow accepts only. Final count is still 12 windows, with `frame_done` arriving later by the number of gap cycles.
5. `in_valid`=1 during the 2nd FLUSH cycle → `err_overrun` pulses 1 cycle, window count stays 12, and `frame_done` timing is unchanged.
6. Reset asserted after the 7th accept, then a new 12-pixel frame → outputs clear on the next cycle. The new frame produces `lb_addr` 0,1,2,3, `lb_sel`=0 and centres (0,0)…(2,3), with no stale `win_valid`.
